// File: rtl/module_output_enco_gray.sv
// Binary-to-Gray output encoder.
// Takes binary words over a valid/ready handshake, buffers one word and
// publishes its Gray code on a registered output. The output changes only on
// a periodic refresh tick, so downstream pins/LEDs update at a slow, safe rate.
module module_output_enco_gray #(
    parameter int WIDTH          = 4,
    parameter int OUTPUT_REFRESH = 2700000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] bin_code_i,
    input  logic             bin_valid_i,
    output logic             bin_ready_o,
    output logic [WIDTH-1:0] gray_code_o,
    output logic             gray_update_o
);

    // Refresh counter sizing; one bit minimum keeps degenerate settings legal.
    localparam int CNT_W = (OUTPUT_REFRESH > 1) ? $clog2(OUTPUT_REFRESH) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(OUTPUT_REFRESH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    // Gray encoding: every bit is XORed with its upper neighbour, MSB passes through.
    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] bin);
        return bin ^ (bin >> 1'b1);
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             tick_r;
    logic             tick_next_s;

    buf_state_t       state_r;
    buf_state_t       state_next_s;
    logic [WIDTH-1:0] hold_r;
    logic [WIDTH-1:0] hold_next_s;
    logic [WIDTH-1:0] gray_code_r;
    logic [WIDTH-1:0] gray_next_s;
    logic             gray_update_r;
    logic             update_next_s;

    // Free-running down-counter; the tick is raised for the cycle after zero.
    always_comb begin
        cnt_next_s  = cnt_r;
        tick_next_s = 1'b0;
        if (cnt_r == CNT_ZERO) begin
            cnt_next_s  = CNT_RELOAD;
            tick_next_s = 1'b1;
        end else begin
            cnt_next_s  = cnt_r - CNT_ONE;
            tick_next_s = 1'b0;
        end
    end

    // Refresh counter and tick registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r  <= CNT_RELOAD;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= tick_next_s;
        end
    end

    // Buffer FSM next-state and output decode. A word accepted on a tick edge
    // is not published on that edge because the FSM is still EMPTY there.
    always_comb begin
        state_next_s  = state_r;
        hold_next_s   = hold_r;
        gray_next_s   = gray_code_r;
        update_next_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (bin_valid_i) begin
                    hold_next_s  = bin_code_i;
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (tick_r) begin
                    gray_next_s   = bin_to_gray(hold_r);
                    update_next_s = 1'b1;
                    state_next_s  = ST_EMPTY;
                end else begin
                    state_next_s  = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Buffer state, hold register and registered Gray outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= ST_EMPTY;
            hold_r        <= {WIDTH{1'b0}};
            gray_code_r   <= {WIDTH{1'b0}};
            gray_update_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            hold_r        <= hold_next_s;
            gray_code_r   <= gray_next_s;
            gray_update_r <= update_next_s;
        end
    end

    assign bin_ready_o   = (state_r == ST_EMPTY);
    assign gray_code_o   = gray_code_r;
    assign gray_update_o = gray_update_r;

endmodule

// File: tb/tb_module_output_enco_gray.sv
// Scoreboard bench for module_output_enco_gray (WIDTH=4, OUTPUT_REFRESH=4).
// A reference process predicts accepts and publish edges from the refresh
// period arithmetic; a monitor compares DUT outputs at every falling edge.
module tb_module_output_enco_gray;

    localparam int R = 4;

    logic       clk;
    logic       rst;
    logic [3:0] bin_code;
    logic       bin_valid;
    logic       bin_ready;
    logic [3:0] gray_code;
    logic       gray_update;

    module_output_enco_gray #(
        .WIDTH          (4),
        .OUTPUT_REFRESH (R)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bin_code_i    (bin_code),
        .bin_valid_i   (bin_valid),
        .bin_ready_o   (bin_ready),
        .gray_code_o   (gray_code),
        .gray_update_o (gray_update)
    );

    // Clock generator.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Gray table for 4-bit words.
    logic [3:0] gray_tab [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    typedef struct {
        logic [3:0] gray;
        int         due;
    } exp_t;

    exp_t q[$];
    int   edge_cnt   = 0;
    bit   model_full = 1'b0;
    int   m_e_old;
    int   m_tick_edge;
    exp_t m_e;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         rd_idx   = 0;
    logic [3:0] last_gray = 4'b0000;
    bit         exp_upd;
    int         test_id  = 0;

    // Reference model: counts edges since reset release, tracks the one-word
    // buffer and schedules each accepted word for the first tick edge after it.
    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            edge_cnt   = 0;
            model_full = 1'b0;
            q.delete();
        end else begin
            m_e_old  = edge_cnt;
            edge_cnt = edge_cnt + 1;
            if (model_full) begin
                if (m_e_old >= R && (m_e_old % R) == 0) model_full = 1'b0;
            end else if (bin_valid) begin
                model_full  = 1'b1;
                m_tick_edge = ((edge_cnt + R - 1) / R) * R;
                m_e.gray    = gray_tab[bin_code];
                m_e.due     = m_tick_edge + 1;
                q.push_back(m_e);
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each update pulse and checks all outputs.
    always begin
        @(negedge clk or posedge rst);
        if (rst) begin
            rd_idx    = 0;
            last_gray = 4'b0000;
            #1;
            check("reset_gray", gray_code, 4'b0000);
            check("reset_update", {3'b000, gray_update}, 4'b0000);
            check("reset_ready", {3'b000, bin_ready}, 4'b0001);
        end else begin
            exp_upd = (rd_idx < q.size()) && (q[rd_idx].due == edge_cnt);
            check("update_pulse", {3'b000, gray_update}, {3'b000, exp_upd});
            if (exp_upd) begin
                last_gray = q[rd_idx].gray;
                rd_idx++;
            end
            check("gray_code", gray_code, last_gray);
            check("ready", {3'b000, bin_ready}, {3'b000, ~model_full});
            if (test_id == 2 && edge_cnt == 5) begin
                check("single_push_edge5", gray_code, 4'b0111);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer a word from a falling edge and hold it until it is accepted.
    task automatic push(input logic [3:0] w);
        int budget;
        budget    = 0;
        bin_valid = 1'b1;
        bin_code  = w;
        while (!bin_ready) begin
            @(negedge clk);
            budget++;
            if (budget > 3 * R) begin
                $display("FAIL push_timeout: word %b not accepted within %0d cycles", w, 3 * R);
                $fatal(1, "push timeout");
            end
        end
        @(posedge clk);
        @(negedge clk);
        bin_valid = 1'b0;
    endtask

    // Global watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int budget;
        rst       = 1'b0;
        bin_valid = 1'b0;
        bin_code  = 4'b0000;

        // Async reset between edges, before any clock edge has occurred.
        test_id = 1;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single push accepted on edge 1, published after edge 5.
        test_id = 2;
        push(4'b0101);
        idle(2 * R);

        // Encode sweep.
        test_id = 3;
        for (int i = 0; i < 16; i++) push(4'(i));
        idle(2 * R);

        // Backpressure: second word held while the first is buffered.
        test_id = 4;
        push(4'b1111);
        push(4'b1010);
        idle(2 * R);

        // Accept exactly on a tick edge: next edge is k*R+1 and buffer is empty.
        test_id = 5;
        budget  = 0;
        while (!(bin_ready && (edge_cnt % R) == 0)) begin
            @(negedge clk);
            budget++;
            if (budget > 4 * R) begin
                $display("FAIL tick_align_timeout: no aligned empty slot found");
                $fatal(1, "align timeout");
            end
        end
        push(4'b0011);
        idle(2 * R);

        // Randomized traffic.
        test_id = 6;
        repeat (30) begin
            idle($urandom_range(0, 5));
            push(4'($urandom_range(0, 15)));
        end
        idle(2 * R);

        // Reset while a word is buffered; nothing may publish afterwards.
        test_id = 7;
        push(4'b0110);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(3 * R + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
